// File: rtl/step_event_resolver.sv
// rtl/step_event_resolver.sv - landing event to tile action resolver with consumable tile write-back
// Optional feature macro: COIN_COMBO_EN (consecutive coins double the award, up to 8x).
module step_event_resolver #(
  parameter int NUM_OF_ROWS = 7,
  parameter int NUM_OF_COLS = 10,
  parameter int TILE_SHIFT  = 6,
  parameter int COIN_SCORE  = 10,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               land,
  input  logic [10:0]        bumpy_x,
  input  logic [10:0]        bumpy_y,
  output logic [3:0]         rd_col,
  output logic [2:0]         rd_row,
  output logic               rd_req,
  input  logic [2:0]         step_type,
  input  logic [7:0]         teleport_cordinates,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [3:0]         wr_col,
  output logic [2:0]         wr_row,
  output logic               bounce,
  output logic               fall,
  output logic               death,
  output logic               level_done,
  output logic               teleport,
  output logic [10:0]        tp_x,
  output logic [10:0]        tp_y,
  output logic [SCORE_W-1:0] score,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_DECIDE,
    S_WRITE
  } state_t;

  localparam logic [2:0] T_REGU = 3'd1;
  localparam logic [2:0] T_GATE = 3'd2;
  localparam logic [2:0] T_COIN = 3'd3;
  localparam logic [2:0] T_PORT = 3'd4;
  localparam logic [2:0] T_SPIK = 3'd5;
  localparam logic [2:0] T_BRAK = 3'd6;

  localparam logic [10:0] COLS_L = 11'(NUM_OF_COLS);
  localparam logic [10:0] ROWS_L = 11'(NUM_OF_ROWS);

  state_t       state;
  logic [3:0]   col_q;
  logic [2:0]   row_q;
  logic [2:0]   type_q;
  logic [7:0]   tpc_q;

  logic [10:0]  col_full;
  logic [10:0]  row_full;
  logic         in_grid;

  logic [SCORE_W:0]   coin_add;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  // Range check uses the full shifted coordinate so wide positions never alias into the grid.
  assign col_full = bumpy_x >> TILE_SHIFT;
  assign row_full = bumpy_y >> TILE_SHIFT;
  assign in_grid  = (col_full < COLS_L) && (row_full < ROWS_L);

`ifdef COIN_COMBO_EN
  logic [1:0] combo_q;
  assign coin_add = (SCORE_W+1)'(COIN_SCORE) << combo_q;
`else
  assign coin_add = (SCORE_W+1)'(COIN_SCORE);
`endif

  assign score_sum  = {1'b0, score} + coin_add;
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  assign rd_col = col_q;
  assign rd_row = row_q;
  assign wr_col = col_q;
  assign wr_row = row_q;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      type_q     <= '0;
      tpc_q      <= '0;
      rd_req     <= 1'b0;
      wr_valid   <= 1'b0;
      bounce     <= 1'b0;
      fall       <= 1'b0;
      death      <= 1'b0;
      level_done <= 1'b0;
      teleport   <= 1'b0;
      tp_x       <= '0;
      tp_y       <= '0;
      score      <= '0;
`ifdef COIN_COMBO_EN
      combo_q    <= '0;
`endif
    end else begin
      rd_req     <= 1'b0;
      bounce     <= 1'b0;
      fall       <= 1'b0;
      death      <= 1'b0;
      level_done <= 1'b0;
      teleport   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (land) begin
            col_q <= col_full[3:0];
            row_q <= row_full[2:0];
            if (in_grid) begin
              state  <= S_QUERY;
              rd_req <= 1'b1;
            end else begin
              fall <= 1'b1;
`ifdef COIN_COMBO_EN
              combo_q <= '0;
`endif
            end
          end
        end

        S_QUERY: begin
          state <= S_WAIT;
        end

        // Map data is valid exactly one cycle after the read strobe.
        S_WAIT: begin
          type_q <= step_type;
          tpc_q  <= teleport_cordinates;
          state  <= S_DECIDE;
        end

        S_DECIDE: begin
          state <= S_IDLE;
`ifdef COIN_COMBO_EN
          if (type_q != T_COIN) begin
            combo_q <= '0;
          end
`endif
          case (type_q)
            T_REGU: begin
              bounce <= 1'b1;
            end
            T_GATE: begin
              bounce     <= 1'b1;
              level_done <= 1'b1;
            end
            T_SPIK: begin
              death <= 1'b1;
            end
            T_PORT: begin
              teleport <= 1'b1;
              tp_x     <= 11'(tpc_q[7:4]) << TILE_SHIFT;
              tp_y     <= 11'(tpc_q[3:0]) << TILE_SHIFT;
            end
            T_BRAK: begin
              bounce   <= 1'b1;
              wr_valid <= 1'b1;
              state    <= S_WRITE;
            end
            T_COIN: begin
              bounce   <= 1'b1;
              score    <= score_next;
              wr_valid <= 1'b1;
              state    <= S_WRITE;
`ifdef COIN_COMBO_EN
              if (combo_q != 2'd3) begin
                combo_q <= combo_q + 2'd1;
              end
`endif
            end
            default: begin
              fall <= 1'b1;
            end
          endcase
        end

        // Clear request stays asserted with a stable target until the map accepts it.
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          state    <= S_IDLE;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_event_resolver.sv
// tb/tb_step_event_resolver.sv - directed table-driven bench for step_event_resolver
module tb_step_event_resolver;

  logic        clk;
  logic        reset;
  logic        land;
  logic [10:0] bumpy_x;
  logic [10:0] bumpy_y;
  logic [3:0]  rd_col;
  logic [2:0]  rd_row;
  logic        rd_req;
  logic [2:0]  step_type;
  logic [7:0]  teleport_cordinates;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_col;
  logic [2:0]  wr_row;
  logic        bounce;
  logic        fall;
  logic        death;
  logic        level_done;
  logic        teleport;
  logic [10:0] tp_x;
  logic [10:0] tp_y;
  logic [15:0] score;
  logic        busy;

  step_event_resolver dut (
    .clk                 (clk),
    .reset               (reset),
    .land                (land),
    .bumpy_x             (bumpy_x),
    .bumpy_y             (bumpy_y),
    .rd_col              (rd_col),
    .rd_row              (rd_row),
    .rd_req              (rd_req),
    .step_type           (step_type),
    .teleport_cordinates (teleport_cordinates),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_col              (wr_col),
    .wr_row              (wr_row),
    .bounce              (bounce),
    .fall                (fall),
    .death               (death),
    .level_done          (level_done),
    .teleport            (teleport),
    .tp_x                (tp_x),
    .tp_y                (tp_y),
    .score               (score),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  st;
    logic [7:0]  tpc;
    logic        oob;
    logic [3:0]  col;
    logic [2:0]  row;
    logic [4:0]  pulses;  // {bounce, fall, death, level_done, teleport}
    logic        wr;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;

  logic [15:0] score_m = 16'd0;
  logic [10:0] tpx_m = 11'd0;
  logic [10:0] tpy_m = 11'd0;
  int          combo_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] pulses_now();
    return {bounce, fall, death, level_done, teleport};
  endfunction

  task automatic model_coin();
    int add;
    int sum;
`ifdef COIN_COMBO_EN
    add = 10 << combo_m;
    if (combo_m < 3) combo_m++;
`else
    add = 10;
`endif
    sum = int'(score_m) + add;
    score_m = (sum > 65535) ? 16'hffff : 16'(sum);
  endtask

  task automatic do_land(input vec_t v);
    @(negedge clk);
    bumpy_x = v.x;
    bumpy_y = v.y;
    land = 1'b1;
    @(negedge clk);
    land = 1'b0;
    chk("t1_rd_req", rd_req, !v.oob);
    if (v.oob) begin
      chk("oob_fall", fall, 1);
      combo_m = 0;
      @(negedge clk);
      chk("oob_busy", busy, 0);
    end else begin
      chk("rd_col", rd_col, v.col);
      chk("rd_row", rd_row, v.row);
      @(negedge clk);
      step_type = v.st;
      teleport_cordinates = v.tpc;
      chk("t2_rd_req", rd_req, 0);
      @(negedge clk);
      step_type = 3'd0;
      teleport_cordinates = 8'h00;
      chk("t3_pulses", pulses_now(), 0);
      @(negedge clk);
      if (v.st == 3'd3) model_coin();
      else combo_m = 0;
      if (v.st == 3'd4) begin
        tpx_m = 11'(v.tpc[7:4]) * 11'd64;
        tpy_m = 11'(v.tpc[3:0]) * 11'd64;
      end
      chk("t4_pulses", pulses_now(), v.pulses);
      chk("t4_score", score, score_m);
      chk("t4_tp_x", tp_x, tpx_m);
      chk("t4_tp_y", tp_y, tpy_m);
      chk("t4_wr_valid", wr_valid, v.wr);
      if (v.wr) begin
        chk("t4_wr_col", wr_col, v.col);
        chk("t4_wr_row", wr_row, v.row);
      end
      @(negedge clk);
      chk("t5_pulses", pulses_now(), 0);
      chk("t5_busy", busy, 0);
      chk("t5_wr_valid", wr_valid, 0);
    end
  endtask

  initial begin
    logic [15:0] exp_d[3];
    vec_t rv;
    int death_cnt;
    int rd_cnt;

    vecs[0]  = '{x:130, y:200, st:1, tpc:8'h00, oob:0, col:2, row:3, pulses:5'b10000, wr:0};
    vecs[1]  = '{x:70,  y:10,  st:0, tpc:8'h00, oob:0, col:1, row:0, pulses:5'b01000, wr:0};
    vecs[2]  = '{x:639, y:447, st:5, tpc:8'h00, oob:0, col:9, row:6, pulses:5'b00100, wr:0};
    vecs[3]  = '{x:0,   y:0,   st:2, tpc:8'h00, oob:0, col:0, row:0, pulses:5'b10010, wr:0};
    vecs[4]  = '{x:300, y:300, st:4, tpc:8'h45, oob:0, col:4, row:4, pulses:5'b00001, wr:0};
    vecs[5]  = '{x:10,  y:10,  st:7, tpc:8'h00, oob:0, col:0, row:0, pulses:5'b01000, wr:0};
    vecs[6]  = '{x:200, y:64,  st:6, tpc:8'h00, oob:0, col:3, row:1, pulses:5'b10000, wr:1};
    vecs[7]  = '{x:700, y:100, st:1, tpc:8'h00, oob:1, col:0, row:0, pulses:5'b01000, wr:0};
    vecs[8]  = '{x:100, y:448, st:1, tpc:8'h00, oob:1, col:0, row:0, pulses:5'b01000, wr:0};
    vecs[9]  = '{x:65,  y:65,  st:4, tpc:8'h00, oob:0, col:1, row:1, pulses:5'b00001, wr:0};
    vecs[10] = '{x:128, y:128, st:3, tpc:8'h00, oob:0, col:2, row:2, pulses:5'b10000, wr:1};
    vecs[11] = '{x:128, y:128, st:3, tpc:8'h00, oob:0, col:2, row:2, pulses:5'b10000, wr:1};

`ifdef COIN_COMBO_EN
    exp_d[0] = 16'd10; exp_d[1] = 16'd30; exp_d[2] = 16'd70;
`else
    exp_d[0] = 16'd10; exp_d[1] = 16'd20; exp_d[2] = 16'd30;
`endif

    reset = 1'b1;
    land = 1'b0;
    bumpy_x = '0;
    bumpy_y = '0;
    step_type = '0;
    teleport_cordinates = '0;
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_pulses", pulses_now(), 0);
    chk("rst_tp", {tp_x, tp_y}, 0);
    chk("rst_idx", {rd_col, rd_row, wr_col, wr_row}, 0);

    for (int i = 0; i < 12; i++) do_land(vecs[i]);

    // COIN with wr_ready held low for three WRITE cycles
    wr_ready = 1'b0;
    rv = '{x:70, y:10, st:3, tpc:8'h00, oob:0, col:1, row:0, pulses:5'b10000, wr:1};
    @(negedge clk);
    bumpy_x = rv.x; bumpy_y = rv.y; land = 1'b1;
    @(negedge clk);
    land = 1'b0;
    @(negedge clk);
    step_type = rv.st;
    @(negedge clk);
    step_type = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        model_coin();
        chk("coin_bounce", bounce, 1);
        chk("coin_score", score, score_m);
      end
      chk("coin_wr_valid", wr_valid, 1);
      chk("coin_wr_col", wr_col, 1);
      chk("coin_wr_row", wr_row, 0);
      if (i == 3) wr_ready = 1'b1;
    end
    @(negedge clk);
    chk("coin_done_busy", busy, 0);
    chk("coin_done_wr_valid", wr_valid, 0);

    // SPIK with a second land pulse while busy
    @(negedge clk);
    bumpy_x = 130; bumpy_y = 200; land = 1'b1;
    @(negedge clk);
    land = 1'b0;
    death_cnt = death ? 1 : 0;
    @(negedge clk);
    step_type = 3'd5;
    land = 1'b1;
    if (death) death_cnt++;
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        land = 1'b0;
        step_type = 3'd0;
      end
      if (i == 1) chk("spik_t4_death", death, 1);
      if (death) death_cnt++;
      if (rd_req) rd_cnt++;
    end
    combo_m = 0;
    chk("spik_death_count", death_cnt, 1);
    chk("spik_no_second_read", rd_cnt, 0);

    // BRAK stalled in WRITE, then reset for one cycle
    wr_ready = 1'b0;
    @(negedge clk);
    bumpy_x = 200; bumpy_y = 64; land = 1'b1;
    @(negedge clk);
    land = 1'b0;
    @(negedge clk);
    step_type = 3'd6;
    @(negedge clk);
    step_type = 3'd0;
    @(negedge clk);
    chk("brak_wr_valid", wr_valid, 1);
    chk("brak_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_ready = 1'b1;
    score_m = 16'd0;
    combo_m = 0;
    tpx_m = 11'd0;
    tpy_m = 11'd0;
    chk("rst_mid_wr_valid", wr_valid, 0);
    chk("rst_mid_score", score, 0);
    chk("rst_mid_busy", busy, 0);
    do_land(vecs[0]);

    // Consecutive coins after a non-coin landing
    for (int i = 0; i < 3; i++) begin
      do_land(vecs[10]);
      chk("combo_score", score, exp_d[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_event_resolver.md
Name: step_event_resolver

Overview:
- Consumer and writer side of the step tile map.
- On each landing event from the Bumpy physics block, it converts Bumpy's pixel position to a grid index and reads the tile type and teleport entry from the map.
- It then issues the game action for that tile (bounce, fall, die, score, teleport, level done).
- For consumable tiles (BRAK, COIN) it issues a write-back request that turns the tile into FREE.
- It sits between the Bumpy movement FSM and the step map / score logic.

Parameters:
- NUM_OF_ROWS, 7: grid rows.
- NUM_OF_COLS, 10: grid columns.
- TILE_SHIFT, 6: log2 of tile size in pixels (64).
- COIN_SCORE, 10: score added per coin.
- SCORE_W, 16: score accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- land  in  1  one-cycle pulse: Bumpy touched a step surface.
- bumpy_x  in  11  Bumpy contact pixel X.
- bumpy_y  in  11  Bumpy contact pixel Y.
- rd_col  out  4  map read column index.
- rd_row  out  3  map read row index.
- rd_req  out  1  map read strobe.
- step_type  in  3  tile code, valid exactly 1 cycle after rd_req.
- teleport_cordinates  in  8  {X idx[7:4], Y idx[3:0]}, valid with step_type.
- wr_valid  out  1  tile clear request.
- wr_ready  in  1  map accepts the clear.
- wr_col  out  4  clear target column.
- wr_row  out  3  clear target row.
- bounce  out  1  pulse: REGU/BRAK/COIN/GATE surface, bounce up.
- fall  out  1  pulse: FREE, no support.
- death  out  1  pulse: SPIK.
- level_done  out  1  pulse: GATE.
- teleport  out  1  pulse: PORT.
- tp_x  out  11  teleport target pixel X, valid with teleport.
- tp_y  out  11  teleport target pixel Y, valid with teleport.
- score  out  SCORE_W  coin score accumulator.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Tile codes: FREE=0, REGU=1, GATE=2, COIN=3, PORT=4, SPIK=5, BRAK=6; code 7 is treated as FREE.
- FSM states are IDLE, QUERY, WAIT, DECIDE, WRITE.
- IDLE:
  - land=1 latches col=bumpy_x>>TILE_SHIFT and row=bumpy_y>>TILE_SHIFT.
  - If col≥NUM_OF_COLS or row≥NUM_OF_ROWS: fall pulses next cycle, no read, return to IDLE.
  - Otherwise go to QUERY.
- QUERY: rd_req=1 for one cycle with rd_col/rd_row held stable, then go to WAIT.
- WAIT: sample step_type and teleport_cordinates, then go to DECIDE.
- DECIDE: exactly one action pulse, 1 cycle wide; this is cycle 4 after the land cycle (land at T0, pulse at T4).
  - REGU: bounce.
  - FREE or 7: fall.
  - SPIK: death.
  - GATE: level_done and bounce.
  - PORT: teleport, with tp_x = X idx<<TILE_SHIFT and tp_y = Y idx<<TILE_SHIFT. An entry of 0x00 is still a teleport to (0,0).
  - BRAK: bounce, then go to WRITE.
  - COIN: bounce, score += COIN_SCORE (saturating at all-ones), then go to WRITE.
  - All other codes return to IDLE.
- WRITE:
  - wr_valid=1 with wr_col/wr_row held until the wr_valid&wr_ready cycle, then go to IDLE.
  - wr_valid never drops before acceptance.
  - wr_ready high on the first WRITE cycle gives a 1-cycle transfer.
- land while busy=1 is ignored, not queued.
- Output defaults:
  - All pulses, rd_req and wr_valid are 0 outside their states.
  - tp_x/tp_y hold their last value.
  - rd_col/rd_row/wr_col/wr_row hold the latched index.
- Reset mid-operation: reset wins in any state.
  - Returns to IDLE and clears score.
  - Deasserts wr_valid immediately; a pending clear is dropped and the tile is unchanged.
- Reset values: every output is 0, state is IDLE.

Optional Feature:
- Macro: COIN_COMBO_EN.
- Enabled:
  - A 2-bit combo counter increments on each COIN, saturating at 3.
  - It resets to 0 on any non-COIN landing.
  - Score added = COIN_SCORE << combo, using the counter value before the increment.
- Disabled: a flat COIN_SCORE per coin; no counter logic is synthesized.

Test Plan:
- Land at (130,200), map returns REGU, wr_ready=1: rd_col=2, rd_row=3, rd_req at T1; bounce only at T4; no wr_valid.
- Land at (70,10) on COIN with wr_ready low 3 cycles: score 0→10; wr_valid held 4 cycles with wr_col=1, wr_row=0; accepted on cycle 4; busy low the next cycle.
- PORT with teleport_cordinates=0x45: teleport pulse with tp_x=256, tp_y=320; no fall, death or bounce.
- Land at (700,100): col 10 is out of grid, so fall pulses at T1; rd_req never asserted.
- SPIK landing, plus a second land pulse at T2: exactly one death pulse; the second land is ignored.
- BRAK in WRITE with wr_ready=0, reset asserted 1 cycle: wr_valid=0 and score=0 next cycle; a later land is processed normally.
- With COIN_COMBO_EN, 3 consecutive coins: score 10, 30, 70.
